// File: rtl/cache_ctrl_2way.sv
// Two-way set-associative, write-through / write-allocate cache controller with
// a pipelined block-fill FSM and saturating hit/miss statistics.
module cache_ctrl_2way #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int SETS    = 64,
    parameter int WORDS   = 8,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_rvalid,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
);

    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;
    localparam int BLK_W = ADDR_W - OFF_W - 1;

    generate
        if (SETS < 2 || WORDS < 2 || MEM_LAT < 1 || TAG_W < 1) begin : g_bad_param
            $error("cache_ctrl_2way: illegal parameter combination");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_FILL} state_t;

    state_t r_state;
    state_t w_next;

    logic [TAG_W-1:0]  r_tag   [2][SETS];
    logic [DATA_W-1:0] r_data  [2][SETS][WORDS];
    logic [SETS-1:0]   r_valid [2];
    logic [SETS-1:0]   r_lru;
    logic [BLK_W-1:0]  r_blk;
    logic              r_vic;
    logic [OFF_W:0]    r_issue;
    logic [OFF_W-1:0]  r_ret;
    logic [15:0]       r_hit_cnt;
    logic [15:0]       r_miss_cnt;

    logic [OFF_W-1:0]  w_off;
    logic [IDX_W-1:0]  w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic              w_req;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_acc_hit;
    logic              w_miss;
    logic              w_victim;
    logic [IDX_W-1:0]  w_fill_idx;
    logic [TAG_W-1:0]  w_fill_tag;
    logic              w_ret_wr;
    logic              w_ret_last;
    logic [DATA_W-1:0] w_rd0;
    logic [DATA_W-1:0] w_rd1;
    logic              w_unused;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Address bit 0 selects a byte within a word and plays no part in lookup.
    assign w_unused   = cpu_addr[0];
    assign w_off      = cpu_addr[OFF_W:1];
    assign w_idx      = cpu_addr[OFF_W+IDX_W:OFF_W+1];
    assign w_tag      = cpu_addr[ADDR_W-1:OFF_W+IDX_W+1];
    assign w_req      = cpu_rd | cpu_wr;

    assign w_hit0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_acc_hit  = (r_state == S_IDLE) && w_req && w_hit;
    assign w_miss     = (r_state == S_IDLE) && w_req && !w_hit;

    assign w_victim   = !r_valid[0][w_idx] ? 1'b0 :
                        !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

    assign w_fill_idx = r_blk[IDX_W-1:0];
    assign w_fill_tag = r_blk[BLK_W-1:IDX_W];
    assign w_ret_wr   = (r_state == S_FILL) && mem_rvalid;
    assign w_ret_last = w_ret_wr && (r_ret == OFF_W'(WORDS - 1));

    assign w_rd0      = r_data[0][w_idx][w_off];
    assign w_rd1      = r_data[1][w_idx][w_off];

    assign hit_cnt    = r_hit_cnt;
    assign miss_cnt   = r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_miss) w_next = S_FILL;
            S_FILL:  if (w_ret_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs are forced to zero while reset is asserted, even with a request pending.
    always_comb begin
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        cpu_rdata = '0;
        if (rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (!w_hit) begin
                            stall = 1'b1;
                        end else if (cpu_wr) begin
                            mem_en    = 1'b1;
                            mem_wr    = 1'b1;
                            mem_addr  = cpu_addr;
                            mem_wdata = cpu_wdata;
                        end else begin
                            cpu_rdata = w_hit1 ? w_rd1 : w_rd0;
                        end
                    end
                end
                S_FILL: begin
                    stall = 1'b1;
                    if (!r_issue[OFF_W]) begin
                        mem_en   = 1'b1;
                        mem_addr = {r_blk, r_issue[OFF_W-1:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_lru      <= '0;
            r_blk      <= '0;
            r_vic      <= 1'b0;
            r_issue    <= '0;
            r_ret      <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_acc_hit) begin
                r_lru[w_idx] <= ~w_hit1;
                r_hit_cnt    <= sat_inc(r_hit_cnt);
            end
            // The victim is invalidated up front so a partial fill can never hit.
            if (w_miss) begin
                r_blk                     <= cpu_addr[ADDR_W-1:OFF_W+1];
                r_vic                     <= w_victim;
                r_valid[w_victim][w_idx]  <= 1'b0;
                r_issue                   <= '0;
                r_ret                     <= '0;
                r_miss_cnt                <= sat_inc(r_miss_cnt);
            end
            if (r_state == S_FILL) begin
                if (!r_issue[OFF_W]) r_issue <= r_issue + (OFF_W+1)'(1);
                if (mem_rvalid) r_ret <= r_ret + OFF_W'(1);
                if (w_ret_last) begin
                    r_valid[r_vic][w_fill_idx] <= 1'b1;
                    r_lru[w_fill_idx]          <= ~r_vic;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ret_wr) begin
            r_data[r_vic][w_fill_idx][r_ret] <= mem_rdata;
        end else if (w_acc_hit && cpu_wr) begin
            r_data[w_hit1][w_idx][w_off] <= cpu_wdata;
        end
        if (w_ret_last) begin
            r_tag[r_vic][w_fill_idx] <= w_fill_tag;
        end
    end

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way against a fixed-latency word memory model.
module tb_cache_ctrl_2way;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        stall;
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic [15:0] hit_cnt;
    logic [15:0] miss_cnt;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] fill_addr [16];
    int          fill_n;
    logic        last_en;
    logic        last_wr;
    logic [15:0] last_addr;
    logic [15:0] last_wdata;

    cache_ctrl_2way #(
        .ADDR_W(16), .DATA_W(16), .SETS(64), .WORDS(8), .MEM_LAT(MEM_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // Main memory: word i initialised to i*3, read data returned MEM_LAT cycles after issue.
    logic [15:0]        mem [0:32767];
    logic [MEM_LAT-1:0] pv;
    logic [15:0]        pa [MEM_LAT];

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'(i * 3);
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pv <= '0;
        else        pv <= {pv[MEM_LAT-2:0], mem_en & ~mem_wr};
    end

    always @(posedge clk) begin
        if (mem_en && mem_wr) mem[mem_addr[15:1]] <= mem_wdata;
        pa[0] <= mem_addr;
        for (int i = MEM_LAT - 1; i > 0; i--) pa[i] <= pa[i-1];
    end

    assign mem_rvalid = pv[MEM_LAT-1];
    assign mem_rdata  = mem[pa[MEM_LAT-1][15:1]];

    // Drives one request (entered just after a rising edge), counts stall cycles
    // and captures the fill issue trace and the completing cycle's outputs.
    task automatic do_req(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, output int ncyc, output logic [15:0] rdata);
        cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
        ncyc = -1; rdata = 16'hxxxx; fill_n = 0;
        last_en = 1'bx; last_wr = 1'bx; last_addr = 16'hxxxx; last_wdata = 16'hxxxx;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (stall) begin
                if (mem_en) begin
                    if (fill_n < 16) fill_addr[fill_n] = mem_addr;
                    fill_n++;
                end
                @(posedge clk); #1;
            end else begin
                ncyc = k; rdata = cpu_rdata;
                last_en = mem_en; last_wr = mem_wr; last_addr = mem_addr; last_wdata = mem_wdata;
                break;
            end
        end
        @(posedge clk); #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
        #12;
        n_total++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b expected 0", stall); else n_pass++;
        n_total++; if (mem_en !== 1'b0 || mem_wr !== 1'b0)
            $display("FAIL reset_mem_ctl: got en=%b wr=%b expected 0/0", mem_en, mem_wr); else n_pass++;
        n_total++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0 || cpu_rdata !== 16'h0)
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected 0", mem_addr, mem_wdata, cpu_rdata); else n_pass++;
        n_total++; if (hit_cnt !== 16'h0 || miss_cnt !== 16'h0)
            $display("FAIL reset_cnt: got hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt); else n_pass++;
        cpu_rd = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_read_miss();
        int n; logic [15:0] rd;
        do_req(1'b1, 1'b0, 16'h0000, 16'h0000, n, rd);
        n_total++; if (n !== 13) $display("FAIL miss_stall_cycles: got %0d expected 13", n); else n_pass++;
        n_total++; if (fill_n !== 8) $display("FAIL miss_issue_count: got %0d expected 8", fill_n); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (fill_addr[i] !== 16'(2 * i))
                $display("FAIL miss_issue_addr%0d: got %h expected %h", i, fill_addr[i], 16'(2 * i));
            else n_pass++;
        end
        n_total++; if (rd !== 16'h0000) $display("FAIL miss_rdata: got %h expected 0000", rd); else n_pass++;
        n_total++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1)
            $display("FAIL miss_counts: got hit=%0d miss=%0d expected 1/1", hit_cnt, miss_cnt); else n_pass++;
    endtask

    task automatic test_read_hit();
        int n; logic [15:0] rd;
        do_req(1'b1, 1'b0, 16'h0006, 16'h0000, n, rd);
        n_total++; if (n !== 0) $display("FAIL hit_stall: got %0d expected 0", n); else n_pass++;
        n_total++; if (rd !== 16'h0009) $display("FAIL hit_rdata: got %h expected 0009", rd); else n_pass++;
        n_total++; if (hit_cnt !== 16'd2) $display("FAIL hit_cnt: got %0d expected 2", hit_cnt); else n_pass++;
    endtask

    task automatic test_write_hit();
        int n; logic [15:0] rd;
        do_req(1'b0, 1'b1, 16'h0004, 16'hBEEF, n, rd);
        n_total++; if (n !== 0) $display("FAIL wr_hit_stall: got %0d expected 0", n); else n_pass++;
        n_total++; if (last_en !== 1'b1 || last_wr !== 1'b1)
            $display("FAIL wr_hit_mem_ctl: got en=%b wr=%b expected 1/1", last_en, last_wr); else n_pass++;
        n_total++; if (last_addr !== 16'h0004 || last_wdata !== 16'hBEEF)
            $display("FAIL wr_hit_mem_data: got addr=%h data=%h expected 0004/beef", last_addr, last_wdata); else n_pass++;
        n_total++; if (hit_cnt !== 16'd3) $display("FAIL wr_hit_cnt: got %0d expected 3", hit_cnt); else n_pass++;
        do_req(1'b1, 1'b0, 16'h0004, 16'h0000, n, rd);
        n_total++; if (n !== 0 || rd !== 16'hBEEF)
            $display("FAIL wr_readback: got stall=%0d data=%h expected 0/beef", n, rd); else n_pass++;
    endtask

    task automatic test_lru();
        int n; logic [15:0] rd;
        do_req(1'b1, 1'b0, 16'h0000, 16'h0000, n, rd);
        n_total++; if (n !== 0 || rd !== 16'h0000)
            $display("FAIL lru_rd0_a: got stall=%0d data=%h expected 0/0000", n, rd); else n_pass++;
        do_req(1'b1, 1'b0, 16'h0400, 16'h0000, n, rd);
        n_total++; if (n !== 13 || rd !== 16'h0600)
            $display("FAIL lru_rd400_a: got stall=%0d data=%h expected 13/0600", n, rd); else n_pass++;
        do_req(1'b1, 1'b0, 16'h0000, 16'h0000, n, rd);
        n_total++; if (n !== 0) $display("FAIL lru_rd0_b: got stall=%0d expected 0", n); else n_pass++;
        do_req(1'b1, 1'b0, 16'h0800, 16'h0000, n, rd);
        n_total++; if (n !== 13 || rd !== 16'h0C00)
            $display("FAIL lru_rd800: got stall=%0d data=%h expected 13/0c00", n, rd); else n_pass++;
        do_req(1'b1, 1'b0, 16'h0000, 16'h0000, n, rd);
        n_total++; if (n !== 0 || rd !== 16'h0000)
            $display("FAIL lru_rd0_c: got stall=%0d data=%h expected 0/0000", n, rd); else n_pass++;
        do_req(1'b1, 1'b0, 16'h0400, 16'h0000, n, rd);
        n_total++; if (n !== 13) $display("FAIL lru_rd400_evicted: got stall=%0d expected 13", n); else n_pass++;
        n_total++; if (miss_cnt !== 16'd4 || hit_cnt !== 16'd10)
            $display("FAIL lru_counts: got hit=%0d miss=%0d expected 10/4", hit_cnt, miss_cnt); else n_pass++;
    endtask

    task automatic test_write_miss();
        int n; logic [15:0] rd;
        do_req(1'b0, 1'b1, 16'h1234, 16'h5A5A, n, rd);
        n_total++; if (n !== 13) $display("FAIL wmiss_stall: got %0d expected 13", n); else n_pass++;
        n_total++; if (fill_n !== 8 || fill_addr[0] !== 16'h1230 || fill_addr[7] !== 16'h123E)
            $display("FAIL wmiss_fill: got n=%0d first=%h last=%h expected 8/1230/123e",
                     fill_n, fill_addr[0], fill_addr[7]); else n_pass++;
        n_total++; if (last_en !== 1'b1 || last_wr !== 1'b1 || last_addr !== 16'h1234 || last_wdata !== 16'h5A5A)
            $display("FAIL wmiss_writethrough: got en=%b wr=%b addr=%h data=%h expected 1/1/1234/5a5a",
                     last_en, last_wr, last_addr, last_wdata); else n_pass++;
        do_req(1'b1, 1'b0, 16'h1234, 16'h0000, n, rd);
        n_total++; if (n !== 0 || rd !== 16'h5A5A)
            $display("FAIL wmiss_readback: got stall=%0d data=%h expected 0/5a5a", n, rd); else n_pass++;
        n_total++; if (miss_cnt !== 16'd5 || hit_cnt !== 16'd12)
            $display("FAIL wmiss_counts: got hit=%0d miss=%0d expected 12/5", hit_cnt, miss_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        int n; logic [15:0] rd;
        cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'h2000;
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (stall !== 1'b1 || mem_en !== 1'b1)
            $display("FAIL midfill_active: got stall=%b en=%b expected 1/1", stall, mem_en); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (stall !== 1'b0 || mem_en !== 1'b0)
            $display("FAIL midfill_reset_out: got stall=%b en=%b expected 0/0", stall, mem_en); else n_pass++;
        n_total++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0)
            $display("FAIL midfill_reset_cnt: got hit=%0d miss=%0d expected 0/0", hit_cnt, miss_cnt); else n_pass++;
        cpu_rd = 1'b0;
        @(negedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(1'b1, 1'b0, 16'h2000, 16'h0000, n, rd);
        n_total++; if (n !== 13 || rd !== 16'h3000)
            $display("FAIL midfill_reissue: got stall=%0d data=%h expected 13/3000", n, rd); else n_pass++;
        n_total++; if (miss_cnt !== 16'd1 || hit_cnt !== 16'd1)
            $display("FAIL midfill_counts: got hit=%0d miss=%0d expected 1/1", hit_cnt, miss_cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_lru();
        test_write_miss();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
